// File: rtl/wb_ram_slave.sv
module wb_ram_slave #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_8000_0000_0000,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_sel_i,
  input  logic [63:0] wb_adr_i,
  input  logic [63:0] wb_dat_i,
  output logic [63:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_adr;
  logic [63:0] r_dat;
  logic        r_we;
  logic [7:0]  r_sel;
  logic [3:0]  r_cnt;
  logic [63:0] r_mem [DEPTH_WORDS];

  logic [63:0]   w_off;
  logic          w_bad;
  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_term;

  // Base is 8-byte aligned, so the offset's low bits equal the address's low bits.
  always_comb begin
    w_off = r_adr - BASE_ADDR;
    w_bad = (r_adr < BASE_ADDR) || (w_off >= SPAN) || (w_off[2:0] != 3'b000);
`ifdef WB_RAM_READONLY_EN
    w_bad = w_bad || r_we;
`endif
    w_idx = w_off[AW+2:3];
  end

  assign w_accept = wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_term      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_term      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_IDLE && w_accept) begin
      r_adr <= wb_adr_i;
      r_dat <= wb_dat_i;
      r_we  <= wb_we_i;
      r_sel <= wb_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      r_cnt    <= '0;
    end else begin
      wb_ack_o <= w_term && !w_bad;
      wb_err_o <= w_term && w_bad;
      if (r_state == S_IDLE && w_accept) begin
        r_cnt <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_term && w_bad) begin
        wb_dat_o <= '0;
      end else if (w_term && !r_we) begin
        wb_dat_o <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && w_term && !w_bad && r_we) begin
      for (int unsigned n = 0; n < 8; n++) begin
        if (r_sel[n]) begin
          r_mem[w_idx][8*n +: 8] <= r_dat[8*n +: 8];
        end
      end
    end
  end

endmodule
